hs4_rx_fifo: RTL and testbench
==============================

// Module: hs4_rx_fifo
// PURPOSE
//  Clocked consumer stage directly downstream of the 2-input 4-phase arbiter.
//  Receives the arbiter's granted request (req + sel + bundled data), stores
//  {sel,data} in a small FIFO and completes the 4-phase handshake on ack_o.
//  Presents entries to synchronous logic on a valid/ready interface.
// PARAMETERS
//  DATA_W  8  width of bundled data word accompanying req_i
//  DEPTH   4  FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1          system clock, all state on rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  req_i      in   1          4-phase request from arbiter (arbiter req_out)
//  sel_i      in   1          index of granted requester (arbiter sel)
//  data_i     in   DATA_W     bundled data, stable while req_i high
//  ack_o      out  1          4-phase acknowledge to arbiter (arbiter ack_out)
//  out_valid  out  1          FIFO non-empty
//  out_ready  in   1          consumer accepts head entry this cycle
//  out_sel    out  1          sel of head entry
//  out_data   out  DATA_W     data of head entry
//  count      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset (async assert, sync release): ack_o=0, out_valid=0, count=0,
//   out_sel/out_data=0, FSM=WAIT_LOW, FIFO pointers=0.
//  req_s = req_i after optional synchronizer (see CONFIGURATION).
//  FSM (hs4_state_t): IDLE, ACK, WAIT_LOW.
//   IDLE:     req_s=1 & !full -> push {sel_i,data_i}, ack_o<=1, -> ACK.
//             req_s=1 & full  -> hold, ack_o stays 0 (backpressure).
//   ACK:      ack_o=1; req_s=0 -> ack_o<=0, -> IDLE.
//   WAIT_LOW: ack_o=0; req_s=0 -> IDLE. Only reached from reset: a req high
//             across reset is never captured (no duplicate of a pre-reset
//             token); arbiter must drop req before a new token is accepted.
//  Exactly one push per req rising phase; req_i held high in ACK never re-pushes.
//  ack_o registered; rises 1 cycle after req_s sampled high, falls 1 cycle
//   after req_s sampled low.
//  FIFO: show-ahead; out_sel/out_data valid whenever out_valid=1.
//   pop when out_valid & out_ready. full = (count==DEPTH), evaluated at cycle
//   start: pop and push in same cycle when full -> pop only, push next cycle.
//   Simultaneous push+pop when non-full, non-empty -> count unchanged.
//   Pointers wrap modulo DEPTH; count is extra-bit wide, never exceeds DEPTH.
//  sel_i/data_i sampled only on the push cycle; ignored otherwise.
// CONFIGURATION
//  HS4_RX_REQ_SYNC_EN defined: req_i passes 2-flop synchronizer (reset 0);
//   req->ack latency 3 cycles; data_i sampled on push cycle (bundled-data
//   setup guaranteed by the arbiter's req timing).
//  Undefined: req_s = req_i directly (same-clock source); latency 1 cycle.
// STRUCTURE
//  hs4_pkg: hs4_state_t enum {IDLE,ACK,WAIT_LOW}; hs4_entry_t struct
//   {logic sel; logic [DATA_W-1:0] data} (parameterised via typedef in module).
//  Sub-module hs4_sync_fifo (DEPTH, entry width): storage, pointers, count,
//   full/empty. Top holds synchronizer + FSM.
// TESTING
//  1 Reset with req_i=0, release, req_i=1 sel=1 data=0xA5 -> ack_o=1 after
//    1 cycle (3 w/ sync); out_valid=1, out_sel=1, out_data=0xA5, count=1.
//  2 Full 4-phase: drop req_i -> ack_o=0 next cycle; keep req_i high 10
//    cycles in ACK -> count stays 1.
//  3 out_ready=0, push 4 tokens (0x01..0x04) -> count=4; 5th req -> ack_o
//    held 0; pulse out_ready one cycle -> pops 0x01, 5th token acked next cycle.
//  4 Wrap: push/pop 10 tokens 0x10..0x19 with out_ready=1 -> popped in order,
//    count never >1 beyond in-flight, no loss.
//  5 Assert rst_n=0 while in ACK with req_i=1 -> ack_o=0 immediately, count=0;
//    release with req_i=1 -> no push; req_i 0 then 1 -> normal capture.
//  6 Arbiter-back-to-back: both requesters (sel 0 then 1) via arbiter -> two
//    entries, out_sel 0 then 1, ack_o toggles twice.

Source files
------------

// File: rtl/hs4_pkg.sv
// Shared types for the hs4 4-phase receive path.
// Holds the handshake FSM state encoding and default geometry.
package hs4_pkg;

    localparam int HS4_DATA_W_DEFAULT = 8;
    localparam int HS4_DEPTH_DEFAULT  = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } hs4_state_t;

endpackage

// File: rtl/hs4_sync_fifo.sv
// Show-ahead single-clock FIFO used by hs4_rx_fifo.
// DEPTH must be a power of two so the pointers wrap naturally.
module hs4_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Full/empty come from the registered count, so both reflect cycle start.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hs4_rx_fifo.sv
// Receives 4-phase tokens from the hs4 arbiter and queues {sel,data} for a clocked consumer.
// Optional macro HS4_RX_REQ_SYNC_EN inserts a 2-flop synchronizer on req_i.
module hs4_rx_fifo
    import hs4_pkg::*;
#(
    parameter int DATA_W = HS4_DATA_W_DEFAULT,
    parameter int DEPTH  = HS4_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_i,
    input  logic                     sel_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic                     ack_o,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sel,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output hs4_state_t               dbg_state
);

    typedef struct packed {
        logic              sel;
        logic [DATA_W-1:0] data;
    } hs4_entry_t;

    localparam int EW = $bits(hs4_entry_t);

    hs4_state_t state;
    hs4_entry_t push_entry;
    hs4_entry_t head_entry;
    logic       req_s;
    logic       push;
    logic       full;
    logic       empty;
    logic [EW-1:0] head_bits;

`ifdef HS4_RX_REQ_SYNC_EN
    logic [1:0] req_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sync <= 2'b00;
        end else begin
            req_sync <= {req_sync[0], req_i};
        end
    end

    assign req_s = req_sync[1];
`else
    assign req_s = req_i;
`endif

    // One push per request phase: only IDLE can push, and IDLE is left on the same edge.
    assign push       = (state == IDLE) & req_s & ~full;
    assign push_entry = '{sel: sel_i, data: data_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LOW;
            ack_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_s && !full) begin
                        ack_o <= 1'b1;
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        ack_o <= 1'b0;
                        state <= IDLE;
                    end
                end
                WAIT_LOW: begin
                    ack_o <= 1'b0;
                    if (!req_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    ack_o <= 1'b0;
                    state <= WAIT_LOW;
                end
            endcase
        end
    end

    hs4_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (out_valid & out_ready),
        .head      (head_bits),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Consumer side: the head entry transfers on any rising edge where out_valid
    // and out_ready are both high; out_sel/out_data hold steady until that edge.
    assign head_entry = hs4_entry_t'(head_bits);
    assign out_valid  = ~empty;
    assign out_sel    = head_entry.sel;
    assign out_data   = head_entry.data;
    assign dbg_state  = state;

endmodule

// File: tb/tb_hs4_rx_fifo.sv
// Self-checking bench for hs4_rx_fifo: directed scenarios plus randomized traffic
// scored against a queue of accepted tokens.
`timescale 1ns/1ps
module tb_hs4_rx_fifo;
    import hs4_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int W      = DATA_W + 1;
    localparam int CW     = $clog2(DEPTH) + 1;
`ifdef HS4_RX_REQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_i;
    logic              sel_i;
    logic [DATA_W-1:0] data_i;
    logic              ack_o;
    logic              out_valid;
    logic              out_ready;
    logic              out_sel;
    logic [DATA_W-1:0] out_data;
    logic [CW-1:0]     count;
    hs4_state_t        dbg_state;

    logic [W-1:0] exp_q[$];
    int   n_vec, n_err, n_pop, n_ack_rise, max_cnt;
    logic prev_ack;
    logic rand_ready;

    always #5 clk = ~clk;

    hs4_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .sel_i     (sel_i),
        .data_i    (data_i),
        .ack_o     (ack_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .out_data  (out_data),
        .count     (count),
        .dbg_state (dbg_state)
    );

    // One clock: predict the pop, advance, then score the FIFO against exp_q.
    task automatic cycle();
        logic         pop_now;
        logic [W-1:0] head;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        pop_now = (exp_q.size() > 0) && out_ready;
        @(posedge clk);
        @(negedge clk);
        if (pop_now) begin
            head = exp_q.pop_front();
            n_pop++;
        end
        if (ack_o && !prev_ack) begin
            exp_q.push_back({sel_i, data_i});
            n_ack_rise++;
        end
        prev_ack = ack_o;
        n_vec++;
        if (count !== CW'(exp_q.size())) begin
            n_err++;
            $display("FAIL count: got %0d expected %0d", count, exp_q.size());
        end
        n_vec++;
        if (out_valid !== (exp_q.size() > 0)) begin
            n_err++;
            $display("FAIL out_valid: got %b expected %b", out_valid, exp_q.size() > 0);
        end
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            n_vec++;
            if ({out_sel, out_data} !== head) begin
                n_err++;
                $display("FAIL head: got sel=%b data=%h expected sel=%b data=%h",
                         out_sel, out_data, head[W-1], head[DATA_W-1:0]);
            end
        end
        if (int'(count) > max_cnt) max_cnt = int'(count);
    endtask

    task automatic wait_ack(input logic val, output int lat);
        lat = 0;
        while (ack_o !== val && lat < 40) begin
            cycle();
            lat++;
        end
        n_vec++;
        if (ack_o !== val) begin
            n_err++;
            $display("FAIL ack_timeout: ack_o=%b expected %b", ack_o, val);
        end
    endtask

    task automatic send_token(input logic s, input logic [DATA_W-1:0] d, input int exp_lat);
        int lat;
        sel_i  = s;
        data_i = d;
        req_i  = 1'b1;
        wait_ack(1'b1, lat);
        if (exp_lat >= 0) begin
            n_vec++;
            if (lat != exp_lat) begin
                n_err++;
                $display("FAIL ack_rise_latency: got %0d expected %0d", lat, exp_lat);
            end
        end
        req_i = 1'b0;
        wait_ack(1'b0, lat);
        n_vec++;
        if (lat != LAT) begin
            n_err++;
            $display("FAIL ack_fall_latency: got %0d expected %0d", lat, LAT);
        end
        sel_i  = 1'($urandom_range(0, 1));
        data_i = DATA_W'($urandom);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (DEPTH + 2) cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_i = 1'b0; sel_i = 1'b0; data_i = '0; out_ready = 1'b0;
        rand_ready = 1'b0; prev_ack = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({ack_o, out_valid, out_sel, out_data, count} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: ack=%b valid=%b sel=%b data=%h count=%0d expected all 0",
                     ack_o, out_valid, out_sel, out_data, count);
        end
        n_vec++;
        if (dbg_state !== WAIT_LOW) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, WAIT_LOW);
        end
        rst_n = 1'b1;
        cycle();
        n_vec++;
        if (dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL idle_after_reset: got %0d expected %0d", dbg_state, IDLE);
        end
    endtask

    task automatic test_capture();
        send_token(1'b1, 8'hA5, LAT);
        n_vec++;
        if (out_valid !== 1'b1 || out_sel !== 1'b1 || out_data !== 8'hA5 || count !== CW'(1)) begin
            n_err++;
            $display("FAIL capture: valid=%b sel=%b data=%h count=%0d expected 1 1 a5 1",
                     out_valid, out_sel, out_data, count);
        end
    endtask

    task automatic test_four_phase();
        int lat;
        drain();
        sel_i = 1'b0; data_i = 8'h3C; req_i = 1'b1;
        wait_ack(1'b1, lat);
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_vec++;
            if (ack_o !== 1'b1 || count !== CW'(1)) begin
                n_err++;
                $display("FAIL hold_in_ack: ack=%b count=%0d expected 1 1", ack_o, count);
            end
        end
        req_i = 1'b0;
        wait_ack(1'b0, lat);
        n_vec++;
        if (lat != LAT) begin
            n_err++;
            $display("FAIL ack_drop_latency: got %0d expected %0d", lat, LAT);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        drain();
        for (int i = 1; i <= DEPTH; i++) send_token(1'($urandom_range(0, 1)), DATA_W'(i), LAT);
        n_vec++;
        if (count !== CW'(DEPTH)) begin
            n_err++;
            $display("FAIL fill: count=%0d expected %0d", count, DEPTH);
        end
        sel_i = 1'b0; data_i = 8'h05; req_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_vec++;
            if (ack_o !== 1'b0) begin
                n_err++;
                $display("FAIL full_backpressure: ack=%b expected 0", ack_o);
            end
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        n_vec++;
        if (ack_o !== 1'b0 || out_data !== 8'h02) begin
            n_err++;
            $display("FAIL pop_when_full: ack=%b head=%h expected 0 02", ack_o, out_data);
        end
        cycle();
        n_vec++;
        if (ack_o !== 1'b1 || count !== CW'(DEPTH)) begin
            n_err++;
            $display("FAIL deferred_push: ack=%b count=%0d expected 1 %0d", ack_o, count, DEPTH);
        end
        req_i = 1'b0;
        wait_ack(1'b0, lat);
        drain();
    endtask

    task automatic test_wrap();
        int pops0;
        pops0 = n_pop;
        max_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_token(1'(i), DATA_W'(8'h10 + i), LAT);
        repeat (3) cycle();
        out_ready = 1'b0;
        n_vec++;
        if (max_cnt > 1 || n_pop - pops0 != 10 || count !== '0) begin
            n_err++;
            $display("FAIL wrap: max_count=%0d pops=%0d count=%0d expected <=1 10 0",
                     max_cnt, n_pop - pops0, count);
        end
    endtask

    task automatic test_reset_in_ack();
        int lat;
        sel_i = 1'b1; data_i = 8'h77; req_i = 1'b1;
        wait_ack(1'b1, lat);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        prev_ack = 1'b0;
        n_vec++;
        if (ack_o !== 1'b0 || count !== '0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: ack=%b count=%0d valid=%b expected 0 0 0", ack_o, count, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_vec++;
            if (ack_o !== 1'b0) begin
                n_err++;
                $display("FAIL no_capture_after_reset: ack=%b expected 0", ack_o);
            end
        end
        req_i = 1'b0;
        repeat (LAT + 2) cycle();
        send_token(1'b0, 8'h5A, LAT);
        n_vec++;
        if (count !== CW'(1) || out_data !== 8'h5A) begin
            n_err++;
            $display("FAIL capture_after_reset: count=%0d data=%h expected 1 5a", count, out_data);
        end
    endtask

    task automatic test_back_to_back();
        int acks0;
        drain();
        acks0 = n_ack_rise;
        send_token(1'b0, 8'hC0, LAT);
        send_token(1'b1, 8'hC1, LAT);
        n_vec++;
        if (n_ack_rise - acks0 != 2 || count !== CW'(2) || out_sel !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first: acks=%0d count=%0d sel=%b expected 2 2 0",
                     n_ack_rise - acks0, count, out_sel);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        n_vec++;
        if (out_sel !== 1'b1 || out_data !== 8'hC1) begin
            n_err++;
            $display("FAIL b2b_second: sel=%b data=%h expected 1 c1", out_sel, out_data);
        end
        drain();
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) cycle();
            send_token(1'($urandom_range(0, 1)), DATA_W'($urandom), -1);
        end
        rand_ready = 1'b0;
        drain();
        n_vec++;
        if (count !== '0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL random_drain: count=%0d valid=%b expected 0 0", count, out_valid);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_pop = 0; n_ack_rise = 0; max_cnt = 0;
        test_reset();
        test_capture();
        test_four_phase();
        test_backpressure();
        test_wrap();
        test_reset_in_ack();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
